// File: rtl/cpu_writeback_pkg.sv
// Shared constants and bundles for the writeback stage.
// Branch kinds and push sources mirror the microcode fields.
package cpu_writeback_pkg;

  localparam logic [1:0] UC_BR_NONE   = 2'd0;
  localparam logic [1:0] UC_BR_ALWAYS = 2'd1;
  localparam logic [1:0] UC_BR_COND   = 2'd2;
  localparam logic [1:0] UC_BR_NCOND  = 2'd3;

  localparam logic [2:0] UC_PUSH_NONE = 3'd0;
  localparam logic [2:0] UC_PUSH_ALU  = 3'd1;
  localparam logic [2:0] UC_PUSH_R0   = 3'd2;
  localparam logic [2:0] UC_PUSH_R1   = 3'd3;
  localparam logic [2:0] UC_PUSH_RET  = 3'd4;
  localparam logic [2:0] UC_PUSH_COND = 3'd5;

  localparam int unsigned TAG_W = 3;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned SW    = TAG_W + XLEN;
  localparam int unsigned POP_W = 11;
  localparam int unsigned MA_W  = 8;

  typedef struct packed {
    logic             redirect;
    logic [XLEN-1:0]  pc_redirect;
    logic             push;
    logic [SW-1:0]    push_data;
    logic [POP_W-1:0] pop;
    logic             we;
    logic [MA_W-1:0]  addr;
    logic [XLEN-1:0]  wdata;
    logic             retire;
  } wb_out_t;

  function automatic logic br_cond(
    input logic [1:0] kind,
    input logic       cond
  );
    logic r;
    r = 1'b0;
    unique case (kind)
      UC_BR_NONE:   r = 1'b0;
      UC_BR_ALWAYS: r = 1'b1;
      UC_BR_COND:   r = cond;
      UC_BR_NCOND:  r = !cond;
      default:      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_wb_killctl.sv
// Kill-window counter: loads on a taken branch, counts down to 0.
// kill is high while the count is nonzero.
import cpu_writeback_pkg::*;

module cpu_wb_killctl #(
  parameter int unsigned KILL_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_b,
  input  logic taken,
  output logic kill
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (taken) begin
      cnt_d = 3'(KILL_CYCLES);
    end else if (cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign kill = (cnt_q != 3'd0);

endmodule

// File: rtl/cpu_writeback.sv
// Stage-4 retire: branch resolve, stack/dmem commit, squash window.
// Define CPU_WB_PERF_EN to add perf_retired/perf_killed counters.
import cpu_writeback_pkg::*;

module cpu_writeback #(
  parameter int unsigned KILL_CYCLES = 2,
  parameter int unsigned INSTR_BYTES = 6
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              alu__cond_3a,
  input  logic [31:0]       alu__out_3a,
  input  logic [1:0]        c__branch_3a,
  input  logic [7:0]        c__mem_addr_3a,
  input  logic              c__mem_write_3a,
  input  logic [2:0]        c__to_push_3a,
  input  logic [47:0]       instruction_3a,
  input  logic [31:0]       pc_3a,
  input  logic [34:0]       r0_3a,
  input  logic [34:0]       r1_3a,
  input  logic [10:0]       st__to_pop_3a,
  output logic              kill_4a,
  output logic              redirect_4a,
  output logic [31:0]       pc_redirect_4a,
  output logic              st__push_4a,
  output logic [34:0]       st__push_data_4a,
  output logic [10:0]       st__pop_4a,
  output logic              dmem_we_4a,
  output logic [7:0]        dmem_addr_4a,
  output logic [31:0]       dmem_wdata_4a,
  output logic              retire_4a
`ifdef CPU_WB_PERF_EN
  ,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_killed
`endif
);

  wb_out_t out_q;
  wb_out_t out_d;

  logic          squash;
  logic          taken;
  logic          pvalid;
  logic [SW-1:0] pdata;
  logic          unused_instr;

  assign unused_instr = ^instruction_3a;

  assign squash = kill_4a;
  assign taken  = !squash &&
                  br_cond(c__branch_3a, alu__cond_3a);

  cpu_wb_killctl #(
    .KILL_CYCLES(KILL_CYCLES)
  ) u_killctl (
    .clk  (clk),
    .rst_b(rst_b),
    .taken(taken),
    .kill (kill_4a)
  );

  always_comb begin
    pvalid = 1'b1;
    pdata  = '0;
    unique case (1'b1)
      (c__to_push_3a == UC_PUSH_ALU):
        pdata = {3'b000, alu__out_3a};
      (c__to_push_3a == UC_PUSH_R0):
        pdata = r0_3a;
      (c__to_push_3a == UC_PUSH_R1):
        pdata = r1_3a;
      (c__to_push_3a == UC_PUSH_RET):
        pdata = {3'b000,
                 pc_3a + 32'(INSTR_BYTES)};
      (c__to_push_3a == UC_PUSH_COND):
        pdata = {34'b0, alu__cond_3a};
      (c__to_push_3a == UC_PUSH_NONE):
        pvalid = 1'b0;
      default:
        pvalid = 1'b0;
    endcase
  end

  always_comb begin
    out_d          = out_q;
    out_d.redirect = taken;
    if (taken) begin
      out_d.pc_redirect = alu__out_3a;
    end
    out_d.push      = !squash && pvalid;
    out_d.push_data = pdata;
    out_d.pop       = squash ? '0 : st__to_pop_3a;
    out_d.we        = !squash && c__mem_write_3a;
    out_d.addr      = c__mem_addr_3a;
    out_d.wdata     = r0_3a[31:0];
    out_d.retire    = !squash;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign redirect_4a      = out_q.redirect;
  assign pc_redirect_4a   = out_q.pc_redirect;
  assign st__push_4a      = out_q.push;
  assign st__push_data_4a = out_q.push_data;
  assign st__pop_4a       = out_q.pop;
  assign dmem_we_4a       = out_q.we;
  assign dmem_addr_4a     = out_q.addr;
  assign dmem_wdata_4a    = out_q.wdata;
  assign retire_4a        = out_q.retire;

`ifdef CPU_WB_PERF_EN
  logic [31:0] ret_cnt_q;
  logic [31:0] kil_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      ret_cnt_q <= '0;
      kil_cnt_q <= '0;
    end else begin
      ret_cnt_q <= ret_cnt_q + 32'(!squash);
      kil_cnt_q <= kil_cnt_q + 32'(squash);
    end
  end

  assign perf_retired = ret_cnt_q;
  assign perf_killed  = kil_cnt_q;
`endif

endmodule
